// File: rtl/soda_pkg.sv
// Shared types and constants for the soda vending controller:
// state encoding, coin codes and the coin-to-cents mapping.
package soda_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_t;

    localparam logic [1:0] COIN_NICKEL  = 2'b00;
    localparam logic [1:0] COIN_DIME    = 2'b01;
    localparam logic [1:0] COIN_QUARTER = 2'b10;
    localparam logic [1:0] COIN_SLUG    = 2'b11;

    localparam int unsigned NICKEL_CENTS  = 5;
    localparam int unsigned DIME_CENTS    = 10;
    localparam int unsigned QUARTER_CENTS = 25;

    // Wide enough for the largest coin; callers extend to their datapath width.
    localparam int unsigned COIN_VALUE_W = 5;

    function automatic logic [COIN_VALUE_W-1:0] coin_value(input logic [1:0] coin_type);
        case (coin_type)
            COIN_NICKEL:  return COIN_VALUE_W'(NICKEL_CENTS);
            COIN_DIME:    return COIN_VALUE_W'(DIME_CENTS);
            COIN_QUARTER: return COIN_VALUE_W'(QUARTER_CENTS);
            default:      return '0;
        endcase
    endfunction

endpackage

// File: rtl/vend_timeout_counter.sv
// Inactivity timer: counts enabled cycles since the last clear and flags
// the cycle in which the count sits at TIMEOUT_CYCLES-1.
module vend_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic done
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Saturates at LAST so done stays asserted if the owner holds off acting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && count != LAST) begin
            count <= count + 1'b1;
        end
    end

    assign done = en && (count == LAST);

endmodule

// File: rtl/soda_vend_ctrl.sv
// Coin-credit and vend controller: accumulates coin credit, requests a vend
// at PRICE, and hands change or a full refund to the hopper.
module soda_vend_ctrl
    import soda_pkg::*;
#(
    parameter int unsigned PRICE          = 75,
    parameter int unsigned CREDIT_W       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    input  logic                cancel,
    input  logic                dispense_ready,
    input  logic                change_ack,
    output logic                coin_accept,
    output logic                coin_reject,
    output logic                vend,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amount,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam logic [CREDIT_W:0]   PRICE_WIDE = (CREDIT_W + 1)'(PRICE);
    localparam logic [CREDIT_W-1:0] PRICE_NARROW = CREDIT_W'(PRICE);

    state_t              state, state_next;
    logic                accept_next, reject_next, vend_next, change_valid_next, busy_next;
    logic [CREDIT_W-1:0] credit_next, change_next;
    logic [CREDIT_W-1:0] coin_cents;
    logic [CREDIT_W:0]   sum;
    logic                coin_legal;
    logic                timer_clear, timer_en, timeout;

    assign coin_cents = CREDIT_W'(coin_value(coin_type));
    assign sum        = {1'b0, credit} + {1'b0, coin_cents};
    assign coin_legal = coin_valid && (coin_type != COIN_SLUG);

    vend_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(timer_clear),
        .en   (timer_en),
        .done (timeout)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            coin_accept   <= 1'b0;
            coin_reject   <= 1'b0;
            vend          <= 1'b0;
            change_valid  <= 1'b0;
            change_amount <= '0;
            credit        <= '0;
            busy          <= 1'b0;
        end else begin
            state         <= state_next;
            coin_accept   <= accept_next;
            coin_reject   <= reject_next;
            vend          <= vend_next;
            change_valid  <= change_valid_next;
            change_amount <= change_next;
            credit        <= credit_next;
            busy          <= busy_next;
        end
    end

    // The timer is held clear outside COLLECT, which also covers entry into it.
    always_comb begin
        state_next        = state;
        accept_next       = 1'b0;
        reject_next       = 1'b0;
        vend_next         = vend;
        change_valid_next = change_valid;
        change_next       = change_amount;
        credit_next       = credit;
        timer_clear       = 1'b1;
        timer_en          = 1'b0;

        case (state)
            IDLE: begin
                if (coin_legal) begin
                    credit_next = coin_cents;
                    accept_next = 1'b1;
                    if ({1'b0, coin_cents} >= PRICE_WIDE) begin
                        state_next = VEND;
                        vend_next  = 1'b1;
                    end else begin
                        state_next = COLLECT;
                    end
                end else if (coin_valid) begin
                    reject_next = 1'b1;
                end
            end
            COLLECT: begin
                timer_clear = 1'b0;
                timer_en    = 1'b1;
                if (cancel || timeout) begin
                    change_next       = credit;
                    credit_next       = '0;
                    change_valid_next = 1'b1;
                    state_next        = CHANGE;
                    reject_next       = coin_valid;
                end else if (coin_legal && !sum[CREDIT_W]) begin
                    credit_next = sum[CREDIT_W-1:0];
                    accept_next = 1'b1;
                    timer_clear = 1'b1;
                    if (sum >= PRICE_WIDE) begin
                        state_next = VEND;
                        vend_next  = 1'b1;
                    end
                end else if (coin_valid) begin
                    reject_next = 1'b1;
                end
            end
            VEND: begin
                reject_next = coin_valid;
                if (dispense_ready) begin
                    vend_next   = 1'b0;
                    change_next = credit - PRICE_NARROW;
                    credit_next = '0;
                    if (credit > PRICE_NARROW) begin
                        change_valid_next = 1'b1;
                        state_next        = CHANGE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            CHANGE: begin
                reject_next = coin_valid;
                if (change_ack) begin
                    change_valid_next = 1'b0;
                    change_next       = '0;
                    state_next        = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next == VEND) || (state_next == CHANGE);
    end

endmodule
